// File: rtl/pdsch_crc_pkg.sv
// Shared constants and types for the PDSCH CRC checker: polynomial table,
// CRC lengths, mode encoding and FSM state codes.
package pdsch_crc_pkg;

   localparam int CRC_W      = 24;
   localparam int CRC24_LEN  = 24;
   localparam int CRC16_LEN  = 16;

   localparam logic [CRC_W-1:0] POLY_CRC24A = 24'h864CFB;
   localparam logic [CRC_W-1:0] POLY_CRC24B = 24'h800063;
   localparam logic [CRC_W-1:0] POLY_CRC16  = 24'h001021;

   typedef enum logic [1:0] {
      MODE_CRC24A = 2'd0,
      MODE_CRC24B = 2'd1,
      MODE_CRC16  = 2'd2,
      MODE_RSVD   = 2'd3
   } crc_mode_e;

   typedef logic [1:0] fsm_state_t;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/pdsch_decoder_crc_checker_par_if.sv
// Block-control and data bus of the CRC checker; master drives start/config/data,
// slave returns busy/done/status.
interface pdsch_decoder_crc_checker_par_if #(
   parameter int DIN_W = 2,
   parameter int LEN_W = 16
);
   logic             i_crc_decode_start;
   logic [1:0]       i_crc_mode;
   logic [LEN_W-1:0] i_blk_len;
   logic [DIN_W-1:0] i_din;
   logic             i_din_vld;
   logic             o_busy;
   logic             o_crc_done;
   logic             o_crc_status;
   logic             o_len_err;

   modport master (
      output i_crc_decode_start, i_crc_mode, i_blk_len, i_din, i_din_vld,
      input  o_busy, o_crc_done, o_crc_status, o_len_err
   );

   modport slave (
      input  i_crc_decode_start, i_crc_mode, i_blk_len, i_din, i_din_vld,
      output o_busy, o_crc_done, o_crc_status, o_len_err
   );
endinterface

// File: rtl/pdsch_crc_lfsr_step.sv
// DIN_W-bit unrolled CRC next-state: non-reflected shift, din[0] consumed first.
// In 16-bit mode the feedback tap moves to bit 15 and bits [23:16] stay zero.
module pdsch_crc_lfsr_step
   import pdsch_crc_pkg::*;
#(
   parameter int DIN_W = 2
) (
   input  logic [CRC_W-1:0] state,
   input  logic [DIN_W-1:0] din,
   input  logic [CRC_W-1:0] poly,
   input  logic             wide,
   output logic [CRC_W-1:0] state_next
);

   logic [CRC_W-1:0] s;
   logic             fb;

   always_comb begin
      s  = state;
      fb = 1'b0;
      for (int i = 0; i < DIN_W; i++) begin
         fb = (wide ? s[CRC_W-1] : s[CRC16_LEN-1]) ^ din[i];
         s  = {s[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
         if (!wide) s[CRC_W-1:CRC16_LEN] = '0;
      end
      state_next = s;
   end

endmodule

// File: rtl/pdsch_decoder_crc_checker_par.sv
// Parallel-input CRC checker for PDSCH code blocks: the whole block including the
// attached CRC is run through the LFSR and a non-zero remainder flags a failure.
module pdsch_decoder_crc_checker_par
   import pdsch_crc_pkg::*;
#(
   parameter int DIN_W = 2,
   parameter int LEN_W = 16
) (
   input  logic                           i_sys_200_clk,
   input  logic                           i_rst,
   pdsch_decoder_crc_checker_par_if.slave bus
);

   fsm_state_t       state;
   crc_mode_e        mode_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_next;
   logic [CRC_W-1:0] crc;
   logic [CRC_W-1:0] crc_next;
   logic [CRC_W-1:0] poly;
   logic             wide;
   logic             status;
   logic             len_err;

   crc_mode_e        start_mode;
   logic [LEN_W-1:0] start_crc_len;
   logic             start_err;

   // Configuration is screened at start so RUN only ever sees lengths the
   // counter reaches exactly, which is what keeps it from wrapping.
   assign start_mode    = crc_mode_e'(bus.i_crc_mode);
   assign start_crc_len = (start_mode == MODE_CRC16) ? LEN_W'(CRC16_LEN) : LEN_W'(CRC24_LEN);
   assign start_err     = (start_mode == MODE_RSVD)
                       || (bus.i_blk_len <= start_crc_len)
                       || ((bus.i_blk_len & LEN_W'(DIN_W-1)) != '0);

   always_comb begin
      poly = POLY_CRC24A;
      wide = 1'b1;
      case (mode_q)
         MODE_CRC24B: poly = POLY_CRC24B;
         MODE_CRC16: begin
            poly = POLY_CRC16;
            wide = 1'b0;
         end
         default: ;
      endcase
   end

   pdsch_crc_lfsr_step #(.DIN_W(DIN_W)) u_step (
      .state      (crc),
      .din        (bus.i_din),
      .poly       (poly),
      .wide       (wide),
      .state_next (crc_next)
   );

   assign cnt_next = cnt + LEN_W'(DIN_W);

   always_ff @(posedge i_sys_200_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         mode_q  <= MODE_CRC24A;
         len_q   <= '0;
         cnt     <= '0;
         crc     <= '0;
         status  <= 1'b0;
         len_err <= 1'b0;
      end else if (bus.i_crc_decode_start) begin
         // Start wins in every state; an in-flight block is dropped silently.
         mode_q  <= start_mode;
         len_q   <= bus.i_blk_len;
         cnt     <= '0;
         crc     <= '0;
         status  <= start_err;
         len_err <= start_err;
         state   <= start_err ? ST_DONE : ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (bus.i_din_vld) begin
                  crc <= crc_next;
                  cnt <= cnt_next;
                  if (cnt_next == len_q) begin
                     status <= |crc_next;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_busy       = (state == ST_RUN);
   assign bus.o_crc_done   = (state == ST_DONE);
   assign bus.o_crc_status = status;
   assign bus.o_len_err    = len_err;

endmodule

// File: tb/tb_pdsch_decoder_crc_checker_par.sv
// Directed bench for the PDSCH CRC checker: "123456789" plus known CRCs, error
// configs, restart, reset and gapped input, with a scoreboard of expected results.
module tb_pdsch_decoder_crc_checker_par;

   localparam int DIN_W = 2;
   localparam int LEN_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pdsch_decoder_crc_checker_par_if #(.DIN_W(DIN_W), .LEN_W(LEN_W)) bus ();

   pdsch_decoder_crc_checker_par #(.DIN_W(DIN_W), .LEN_W(LEN_W)) dut (
      .i_sys_200_clk (clk),
      .i_rst         (rst),
      .bus           (bus)
   );

   int total    = 0;
   int bad      = 0;
   int done_cnt = 0;
   logic [1:0] sb[$];   // {len_err, status}
   bit stream[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [1:0] e;
      if (!rst && bus.o_crc_done === 1'b1) begin
         done_cnt++;
         chk("sb_expected_done", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_lenerr_status", {bus.o_len_err, bus.o_crc_status}, e);
         end
      end
   end

   // "123456789" then the attached CRC, each byte MSB-first; optional bit flip.
   task automatic build(input int mode, input int flip);
      logic [7:0] bytes[$];
      logic [7:0] b;
      bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      case (mode)
         0: begin bytes.push_back(8'hCD); bytes.push_back(8'hE7); bytes.push_back(8'h03); end
         1: begin bytes.push_back(8'h23); bytes.push_back(8'hEF); bytes.push_back(8'h52); end
         default: begin bytes.push_back(8'h31); bytes.push_back(8'hC3); end
      endcase
      stream.delete();
      foreach (bytes[i]) begin
         b = bytes[i];
         for (int k = 7; k >= 0; k--) stream.push_back(b[k]);
      end
      if (flip >= 0) stream[flip] = ~stream[flip];
   endtask

   // Runs the current stream; stop_at>=0 leaves the block unfinished after that many beats.
   task automatic run_block(input logic [1:0] mode, input int gap, input int stop_at,
                            input logic exp_status);
      int nb;
      nb = stream.size() / DIN_W;
      if (stop_at < 0) sb.push_back({1'b0, exp_status});
      @(negedge clk);
      bus.i_crc_decode_start = 1'b1;
      bus.i_crc_mode         = mode;
      bus.i_blk_len          = LEN_W'(stream.size());
      bus.i_din              = 2'b11;
      bus.i_din_vld          = 1'b1;
      @(negedge clk);
      bus.i_crc_decode_start = 1'b0;
      bus.i_din_vld          = 1'b0;
      chk("busy_after_start", bus.o_busy, 1);
      for (int b = 0; b < nb; b++) begin
         if (b == stop_at) return;
         bus.i_din     = {stream[2*b+1], stream[2*b]};
         bus.i_din_vld = 1'b1;
         @(negedge clk);
         if (b != nb - 1) begin
            chk("busy_mid_block", {bus.o_busy, bus.o_crc_done}, 2'b10);
            bus.i_din_vld = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      chk("done_after_last_beat", bus.o_crc_done, 1);
      chk("busy_in_done", bus.o_busy, 0);
      bus.i_din     = 2'b01;
      bus.i_din_vld = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", bus.o_crc_done, 0);
      chk("status_held", bus.o_crc_status, exp_status);
      bus.i_din_vld = 1'b0;
   endtask

   task automatic len_err_case(input logic [1:0] mode, input int len);
      sb.push_back(2'b11);
      @(negedge clk);
      bus.i_crc_decode_start = 1'b1;
      bus.i_crc_mode         = mode;
      bus.i_blk_len          = LEN_W'(len);
      bus.i_din_vld          = 1'b1;
      @(negedge clk);
      bus.i_crc_decode_start = 1'b0;
      chk("lerr_done", bus.o_crc_done, 1);
      chk("lerr_flags", {bus.o_len_err, bus.o_crc_status}, 2'b11);
      chk("lerr_busy0", bus.o_busy, 0);
      @(negedge clk);
      bus.i_din_vld = 1'b0;
      chk("lerr_after", {bus.o_busy, bus.o_crc_done, bus.o_len_err}, 3'b001);
   endtask

   initial begin
      int d0;
      bus.i_crc_decode_start = 1'b0;
      bus.i_crc_mode         = 2'd0;
      bus.i_blk_len          = '0;
      bus.i_din              = '0;
      bus.i_din_vld          = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {bus.o_busy, bus.o_crc_done, bus.o_crc_status, bus.o_len_err}, 4'b0000);
      rst = 1'b0;

      build(0, -1); run_block(2'd0, 0, -1, 1'b0);
      build(1, -1); run_block(2'd1, 0, -1, 1'b0);
      build(2, -1); run_block(2'd2, 0, -1, 1'b0);
      build(0, 5);  run_block(2'd0, 0, -1, 1'b1);
      @(negedge clk);
      chk("flip_held", {bus.o_len_err, bus.o_crc_status}, 2'b01);
      build(1, 70); run_block(2'd1, 0, -1, 1'b1);

      len_err_case(2'd3, 96);
      len_err_case(2'd0, 24);
      len_err_case(2'd0, 97);
      len_err_case(2'd2, 16);

      // restart mid-block: only the second block reports
      build(0, -1);
      d0 = done_cnt;
      run_block(2'd0, 0, 20, 1'b0);
      run_block(2'd0, 0, -1, 1'b0);
      repeat (3) @(negedge clk);
      chk("restart_one_done", done_cnt, d0 + 1);

      build(0, -1); run_block(2'd0, 1, -1, 1'b0);
      build(0, -1); run_block(2'd0, 3, -1, 1'b0);
      build(2, -1); run_block(2'd2, 3, -1, 1'b0);
      build(0, 40); run_block(2'd0, 1, -1, 1'b1);

      // reset mid-block
      build(0, -1);
      run_block(2'd0, 0, 10, 1'b0);
      chk("busy_before_reset", bus.o_busy, 1);
      rst = 1'b1;
      #1;
      chk("reset_mid_outputs", {bus.o_busy, bus.o_crc_done, bus.o_crc_status, bus.o_len_err}, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 60; i++) begin
         bus.i_din     = 2'($urandom_range(0, 3));
         bus.i_din_vld = 1'b1;
         @(negedge clk);
      end
      bus.i_din_vld = 1'b0;
      chk("no_done_after_reset", done_cnt, d0);
      chk("idle_after_reset", bus.o_busy, 0);

      build(1, -1); run_block(2'd1, 0, -1, 1'b0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pdsch_decoder_crc_checker_par.md
PDSCH_DECODER_CRC_CHECKER_PAR -- requirements
Module: pdsch_decoder_crc_checker_par

Interface
REQ-001 SHALL have parameter DIN_W, default 2, meaning bits accepted per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the block-length input.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_sys_200_clk  input  1  system clock, all state on its rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_crc_decode_start  input  1  single-cycle pulse that begins a block and latches i_crc_mode and i_blk_len.
REQ-007 i_crc_mode  input  2  polynomial select: 0=CRC24A (0x864CFB), 1=CRC24B (0x800063), 2=CRC16 (0x1021), 3=reserved.
REQ-008 i_blk_len  input  LEN_W  total bits in the block, payload plus attached CRC.
REQ-009 i_din  input  DIN_W  data beat; bit 0 is the earliest bit in transmission order.
REQ-010 i_din_vld  input  1  i_din qualifier.
REQ-011 o_busy  output  1  high while a block is being accepted.
REQ-012 o_crc_done  output  1  one-cycle pulse marking that the result is valid.
REQ-013 o_crc_status  output  1  1=fail, 0=pass; held until the next start.
REQ-014 o_len_err  output  1  configuration error flag; held until the next start.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 Start in any state SHALL clear the CRC register and the bit counter, latch mode and length, clear status and len_err, and go to RUN next cycle.
- Start while in RUN aborts the current block; no o_crc_done is produced for the aborted block.
REQ-017 SHALL ignore i_din_vld in IDLE, in DONE, and in the start cycle.
REQ-018 In RUN, each valid beat SHALL advance the LFSR by DIN_W bits in bit-0-first order.
- LFSR: init 0, non-reflected, no output XOR.
- All bits, including the attached CRC bits, are fed through the LFSR.
REQ-019 The bit counter SHALL increment by DIN_W per valid beat; when it reaches the latched length, the FSM SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with o_crc_done=1 and o_crc_status=(remainder!=0); the FSM then returns to IDLE.
- Latency: o_crc_done is high one cycle after the last beat is accepted.
REQ-021 CRC16 mode SHALL use register bits [15:0]; bits [23:16] SHALL be held at 0.
REQ-022 Length error SHALL be raised at start when any of the following holds: mode==3, blk_len<=CRC length (24 or 16), or blk_len not a multiple of DIN_W.
- On error: FSM goes to DONE directly, o_len_err=1, o_crc_status=1, o_crc_done pulses one cycle after start.
REQ-023 o_busy SHALL be 1 exactly while in RUN.
REQ-024 The counter SHALL be LEN_W bits wide and SHALL never wrap, because the length is checked before RUN is entered.

Reset
REQ-025 Reset SHALL force IDLE, with CRC register=0, counter=0, o_busy=0, o_crc_done=0, o_crc_status=0 and o_len_err=0.
REQ-026 Reset asserted mid-block SHALL abandon the block with no o_crc_done; after release the block waits for a new start.

Structure
REQ-027 Package pdsch_crc_pkg SHALL hold:
- the mode enum,
- the three polynomial constants,
- the CRC-length constants (24, 16),
- the FSM state typedef.
REQ-028 Sub-module pdsch_crc_lfsr_step SHALL be the combinational DIN_W-bit unrolled next-state function (inputs: state, din, polynomial; output: next state), instantiated once.

Verification
REQ-029 DIN_W=2, mode 0, blk_len=96, ASCII "123456789" sent MSB-first per byte followed by CRC 0xCDE703 MSB-first -> o_crc_done pulses one cycle after beat 48, o_crc_status=0.
REQ-030 Same as REQ-029 with mode 1 and CRC 0x23EF52 -> pass; same as REQ-029 with mode 2, blk_len=88 and CRC 0x31C3 -> pass.
REQ-031 Same as REQ-029 with one payload bit flipped -> o_crc_status=1, o_len_err=0.
REQ-032 Three separate starts: (a) mode=3; (b) blk_len=24 in mode 0; (c) blk_len=97 with DIN_W=2.
- Each -> o_len_err=1, o_crc_status=1, o_crc_done one cycle after start, o_busy never 1.
REQ-033 Restart at beat 20, followed by a full valid block -> exactly one o_crc_done, pass.
REQ-034 Reset asserted at beat 10 -> all outputs 0 immediately, and no later done pulse without a new start.
REQ-035 Beats with i_din_vld gaps (1, 3 idle cycles) -> result identical to a gapless run.
